// File: rtl/debug_unit_pkg.sv
// Shared types and constants for the debug unit (send/receive framing).
package debug_unit_pkg;

    localparam int NB_STATE_PKG = 3;

    typedef enum logic [NB_STATE_PKG-1:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_PC     = 3'd2,
        ST_REGS   = 3'd3,
        ST_MEM    = 3'd4,
        ST_CYCLES = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_SEND = 2'd1,
        SER_WAIT = 2'd2
    } ser_state_e;

    localparam logic [7:0]  TX_HEADER        = 8'hAA;
    localparam logic [7:0]  RX_HEADER        = 8'h55;
    localparam logic [31:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;

    // Header byte, PC word, register file, data memory, cycle counter.
    function automatic int FRAME_BYTES(input int n_regs, input int n_mem);
        return 1 + 4 + 4 * n_regs + 4 * n_mem + 4;
    endfunction

endpackage

// File: rtl/debug_unit_send_if.sv
// UART transmit handshake plus the datapath debug read ports seen by the send unit.
interface debug_unit_send_if #(
    parameter int N_BITS      = 8,
    parameter int N_BITS_DATA = 32,
    parameter int N_BITS_REG  = 5,
    parameter int N_BITS_MEM  = 5
);
    logic [N_BITS-1:0]      tx_data;
    logic                   tx_start;
    logic                   tx_done;
    logic [N_BITS_REG-1:0]  reg_addr;
    logic [N_BITS_DATA-1:0] reg_data;
    logic [N_BITS_MEM-1:0]  mem_addr;
    logic [N_BITS_DATA-1:0] mem_data;

    modport master (
        output tx_data, tx_start, reg_addr, mem_addr,
        input  tx_done, reg_data, mem_data
    );

    modport slave (
        input  tx_data, tx_start, reg_addr, mem_addr,
        output tx_done, reg_data, mem_data
    );
endinterface

// File: rtl/debug_unit_word_serializer.sv
// Sends one word MSB byte first over a start/done byte handshake (or only its top byte).
module debug_unit_word_serializer
    import debug_unit_pkg::*;
#(
    parameter int N_BITS      = 8,
    parameter int N_BITS_DATA = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic                   i_one_byte,
    input  logic [N_BITS_DATA-1:0] i_word,
    input  logic                   i_tx_done,
    output logic [N_BITS-1:0]      o_tx_data,
    output logic                   o_tx_start,
    output logic                   o_idle,
    output logic                   o_word_done
);
    localparam int BYTES       = N_BITS_DATA / N_BITS;
    localparam int N_BITS_BCNT = (BYTES > 1) ? $clog2(BYTES) : 1;

    ser_state_e             state_q, state_d;
    logic [N_BITS_DATA-1:0] shift_q, shift_d;
    logic [N_BITS_BCNT-1:0] byte_cnt_q, byte_cnt_d;
    logic [N_BITS_BCNT-1:0] last_q, last_d;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= SER_IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        last_d      = last_q;
        o_tx_start  = 1'b0;
        o_idle      = 1'b0;
        o_word_done = 1'b0;
        o_tx_data   = shift_q[N_BITS_DATA-1 -: N_BITS];
        case (state_q)
            SER_IDLE: begin
                o_idle = 1'b1;
                if (i_load) begin
                    shift_d    = i_word;
                    byte_cnt_d = '0;
                    last_d     = i_one_byte ? '0 : N_BITS_BCNT'(BYTES - 1);
                    state_d    = SER_SEND;
                end
            end
            SER_SEND: begin
                o_tx_start = 1'b1;
                state_d    = SER_WAIT;
            end
            SER_WAIT: begin
                // Done pulses are only honoured here, so a stray one elsewhere cannot skip a byte.
                if (i_tx_done) begin
                    shift_d = shift_q << N_BITS;
                    if (byte_cnt_q == last_q) begin
                        o_word_done = 1'b1;
                        byte_cnt_d  = '0;
                        state_d     = SER_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = SER_SEND;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

endmodule

// File: rtl/debug_unit_send.sv
// Debug unit transmit side: snapshots PC/regs/mem/cycles and streams them as one UART frame.
module debug_unit_send
    import debug_unit_pkg::*;
#(
    parameter int N_BITS      = 8,
    parameter int N_BITS_DATA = 32,
    parameter int N_BITS_REG  = 5,
    parameter int N_BITS_MEM  = 5,
    parameter int NB_STATE    = 3
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_send,
    input  logic [N_BITS_DATA-1:0] i_pc,
    input  logic [N_BITS_DATA-1:0] i_cycle_count,
    debug_unit_send_if.master      bus,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic [NB_STATE-1:0]    o_state
);
    localparam int N_REGS     = 2 ** N_BITS_REG;
    localparam int N_MEM      = 2 ** N_BITS_MEM;
    localparam int N_BITS_CNT = (N_BITS_REG > N_BITS_MEM) ? N_BITS_REG : N_BITS_MEM;

    state_e                 state_q, state_d;
    logic [N_BITS_CNT-1:0]  word_cnt_q, word_cnt_d;
    logic                   ld_q, ld_d;
    logic [N_BITS_DATA-1:0] pc_q, pc_d;
    logic [N_BITS_DATA-1:0] cyc_q, cyc_d;

    logic                   ser_load;
    logic                   ser_one_byte;
    logic [N_BITS_DATA-1:0] ser_word;
    logic                   ser_idle;
    logic                   ser_word_done;

    debug_unit_word_serializer #(
        .N_BITS      (N_BITS),
        .N_BITS_DATA (N_BITS_DATA)
    ) u_ser (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_load      (ser_load),
        .i_one_byte  (ser_one_byte),
        .i_word      (ser_word),
        .i_tx_done   (bus.tx_done),
        .o_tx_data   (bus.tx_data),
        .o_tx_start  (bus.tx_start),
        .o_idle      (ser_idle),
        .o_word_done (ser_word_done)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            ld_q       <= 1'b0;
            pc_q       <= '0;
            cyc_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            ld_q       <= ld_d;
            pc_q       <= pc_d;
            cyc_q      <= cyc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        ld_d          = ld_q;
        pc_d          = pc_q;
        cyc_d         = cyc_q;
        ser_load      = 1'b0;
        ser_one_byte  = 1'b0;
        ser_word      = '0;
        o_busy        = 1'b1;
        o_frame_done  = 1'b0;
        bus.reg_addr  = '0;
        bus.mem_addr  = '0;
        case (state_q)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_send) begin
                    pc_d    = i_pc;
                    cyc_d   = i_cycle_count;
                    state_d = ST_HEADER;
                end
            end
            ST_DONE: begin
                o_frame_done = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                // Address goes out one cycle, the read data is loaded the next.
                if (ld_q) begin
                    ser_load = 1'b1;
                    ld_d     = 1'b0;
                end else if (ser_idle) begin
                    ld_d = 1'b1;
                end
                case (state_q)
                    ST_HEADER: begin
                        ser_word     = {TX_HEADER, {(N_BITS_DATA-8){1'b0}}};
                        ser_one_byte = 1'b1;
                        if (ser_word_done) state_d = ST_PC;
                    end
                    ST_PC: begin
                        ser_word = pc_q;
                        if (ser_word_done) state_d = ST_REGS;
                    end
                    ST_REGS: begin
                        bus.reg_addr = word_cnt_q[N_BITS_REG-1:0];
                        ser_word     = bus.reg_data;
                        if (ser_word_done) begin
                            if (word_cnt_q == N_BITS_CNT'(N_REGS - 1)) begin
                                word_cnt_d = '0;
                                state_d    = ST_MEM;
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_MEM: begin
                        bus.mem_addr = word_cnt_q[N_BITS_MEM-1:0];
                        ser_word     = bus.mem_data;
                        if (ser_word_done) begin
                            if (word_cnt_q == N_BITS_CNT'(N_MEM - 1)) begin
                                word_cnt_d = '0;
                                state_d    = ST_CYCLES;
                            end else begin
                                word_cnt_d = word_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_CYCLES: begin
                        ser_word = cyc_q;
                        if (ser_word_done) state_d = ST_DONE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        endcase
    end

    assign o_state = NB_STATE'(state_q);

endmodule

// File: tb/tb_debug_unit_send.sv
// Directed bench for debug_unit_send: UART byte model, reg/mem read models, frame scoreboard.
module tb_debug_unit_send;

    logic        clk = 1'b0;
    logic        rst;
    logic        send;
    logic [31:0] pc, cyc;
    logic        o_busy, o_frame_done;
    logic [2:0]  o_state;

    debug_unit_send_if bus ();

    debug_unit_send dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_send        (send),
        .i_pc          (pc),
        .i_cycle_count (cyc),
        .bus           (bus),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Synchronous debug read ports: reg[k] = k, mem[k] = 0xA0000000 + k.
    initial begin
        bus.reg_data = '0;
        bus.mem_data = '0;
    end
    always @(posedge clk) begin
        bus.reg_data <= {27'd0, bus.reg_addr};
        bus.mem_data <= 32'hA000_0000 | {27'd0, bus.mem_addr};
    end

    // UART tx model and protocol monitor, evaluated mid-cycle.
    int        lat = 10;
    bit        same_done = 0;
    bit        spur_en = 0;
    int        cd = 0;
    int        idx;
    int        starts = 0;
    int        fd_cnt = 0;
    int        v_consec = 0, v_idle = 0, v_sect = 0, v_addr = 0;
    bit        prev_start = 0;
    logic      dn;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    function automatic logic [2:0] sect_of(input int i);
        if (i == 0)   return 3'd1;
        if (i < 5)    return 3'd2;
        if (i < 133)  return 3'd3;
        if (i < 261)  return 3'd4;
        return 3'd5;
    endfunction

    initial bus.tx_done = 1'b0;
    always @(negedge clk) begin
        dn = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) dn = 1'b1;
        end
        if (bus.tx_start) begin
            cd = lat;
            if (same_done) dn = 1'b1;
            starts++;
            idx = got_q.size();
            got_q.push_back(bus.tx_data);
            if (prev_start) v_consec++;
            if (o_state == 3'd0 || o_state == 3'd6) v_idle++;
            if (o_state != sect_of(idx)) v_sect++;
            if (o_state == 3'd3 && bus.reg_addr != 5'((idx - 5) / 4)) v_addr++;
            if (o_state == 3'd4 && bus.mem_addr != 5'((idx - 133) / 4)) v_addr++;
        end else if (spur_en && o_busy && cd == 0 && !dn) begin
            dn = 1'b1;
        end
        prev_start = bus.tx_start;
        if (o_state != 3'd3 && bus.reg_addr != 5'd0) v_addr++;
        if (o_state != 3'd4 && bus.mem_addr != 5'd0) v_addr++;
        if (o_frame_done) fd_cnt++;
        bus.tx_done = dn;
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic build_exp(input logic [31:0] p, input logic [31:0] c);
        exp_q.delete();
        exp_q.push_back(8'hAA);
        push_word(p);
        for (int k = 0; k < 32; k++) push_word(32'(k));
        for (int k = 0; k < 32; k++) push_word(32'hA000_0000 + 32'(k));
        push_word(c);
    endtask

    task automatic cmp_frame(input string tag);
        int nerr = 0;
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) nerr++;
        check({tag, "_len"}, got_q.size(), 265);
        check({tag, "_bytes_bad"}, nerr, 0);
        check({tag, "_starts"}, starts, 265);
        check({tag, "_frame_done_pulses"}, fd_cnt, 1);
        if (got_q.size() == 265) begin
            check({tag, "_byte0"}, got_q[0], 8'hAA);
            check({tag, "_byte4"}, got_q[4], 8'h40);
            check({tag, "_byte264"}, got_q[264], 8'h2C);
        end
    endtask

    task automatic start_frame(input logic [31:0] p, input logic [31:0] c);
        got_q.delete();
        starts = 0;
        fd_cnt = 0;
        pc   = p;
        cyc  = c;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        pc   = 32'hDEAD_BEEF;
        cyc  = 32'h0BAD_F00D;
    endtask

    task automatic wait_frame(input string tag, input bit send_in_done);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 6000) begin
            @(negedge clk);
            n++;
            if (o_frame_done) begin
                seen = 1;
                check({tag, "_busy_in_done"}, o_busy, 1'b1);
            end
        end
        check({tag, "_frame_done_seen"}, seen, 1'b1);
        if (send_in_done) send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check({tag, "_busy_after"}, o_busy, 1'b0);
        check({tag, "_state_after"}, o_state, 3'd0);
    endtask

    task automatic wait_bytes(input int nb);
        int n = 0;
        while (got_q.size() < nb && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("wait_bytes_reached", got_q.size() >= nb, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; send = 1'b0; pc = '0; cyc = '0;
        repeat (3) @(negedge clk);
        check("rst_state", o_state, 3'd0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_frame_done", o_frame_done, 1'b0);
        check("rst_tx_start", bus.tx_start, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_reg_addr", bus.reg_addr, 5'd0);
        check("rst_mem_addr", bus.mem_addr, 5'd0);
        rst = 1'b0;
        @(negedge clk);

        // Plain frame, snapshot inputs scrambled right after the trigger.
        lat = 10;
        start_frame(32'h40, 32'h12C);
        check("f1_busy_next", o_busy, 1'b1);
        check("f1_state_header", o_state, 3'd1);
        wait_frame("f1", 1'b0);
        build_exp(32'h40, 32'h12C);
        cmp_frame("f1");

        // Re-trigger mid-frame and again in the DONE cycle: both ignored.
        start_frame(32'h40, 32'h12C);
        wait_bytes(50);
        pc = 32'h44; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_frame("f2", 1'b1);
        repeat (20) @(negedge clk);
        check("f2_idle_busy", o_busy, 1'b0);
        cmp_frame("f2");

        // Stray done pulses whenever the unit is not waiting on a byte.
        lat = 3; spur_en = 1;
        start_frame(32'h40, 32'h12C);
        wait_frame("f3", 1'b0);
        spur_en = 0;
        cmp_frame("f3");

        // Minimum latency: done in the start cycle (ignored) and the cycle after.
        lat = 1; same_done = 1;
        start_frame(32'h40, 32'h12C);
        wait_frame("f4", 1'b0);
        same_done = 0;
        cmp_frame("f4");

        // Reset during MEM word 7 byte 2, then restart from the header.
        lat = 10;
        start_frame(32'h40, 32'h12C);
        wait_bytes(164);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_state", o_state, 3'd0);
        check("rst_mid_busy", o_busy, 1'b0);
        check("rst_mid_tx_start", bus.tx_start, 1'b0);
        check("rst_mid_mem_addr", bus.mem_addr, 5'd0);
        repeat (15) @(negedge clk);
        check("rst_mid_no_new_starts", starts, 164);
        check("rst_mid_idle", o_busy, 1'b0);
        start_frame(32'h40, 32'h12C);
        wait_frame("f5", 1'b0);
        cmp_frame("f5");

        check("no_back_to_back_start", v_consec, 0);
        check("no_start_idle_done", v_idle, 0);
        check("start_in_right_section", v_sect, 0);
        check("addr_sweep_and_hold", v_addr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
